xy_write_arbiter: RTL and testbench

XY_WRITE_ARBITER -- requirements
Module: xy_write_arbiter

---
 rtl/xy_write_arbiter_pkg.sv | 16 +
 rtl/xy_write_arbiter_queue.sv | 105 ++++++++++
 rtl/xy_write_arbiter.sv | 122 ++++++++++++
 tb/tb_xy_write_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_write_arbiter_pkg.sv
// Shared definitions for the XY memory write path.
// XY_DATA_WIDTH : default XY memory word width
// XY_MEM_DEPTH  : XY memory address bits per bank; the write address adds one bank-select bit
// XyWriteReq    : packed write request (addr, data) at the default widths
package xy_write_arbiter_pkg;

    localparam int unsigned XY_DATA_WIDTH = 16;
    localparam int unsigned XY_MEM_DEPTH  = 7;
    localparam int unsigned XY_ADDR_WIDTH = XY_MEM_DEPTH + 1;

    typedef struct packed {
        logic [XY_ADDR_WIDTH-1:0] addr;
        logic [XY_DATA_WIDTH-1:0] data;
    } XyWriteReq;

endpackage

// File: rtl/xy_write_arbiter_queue.sv
// xy_write_queue: host write FIFO with a per-entry live bit and a parallel address-match kill.
// Killed entries keep their slot (physical occupancy) until popped, but stop counting as live.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push, push_addr/data  enqueue at tail (caller guarantees !full)
//   pop                   drop head entry (live or killed)
//   kill, kill_addr       clear the live bit of every entry whose address matches
//   head_addr/data        head entry contents
//   head_live             head entry present and not killed
//   empty, full           physical occupancy flags
//   live_count            registered count of live entries
module xy_write_queue
    import xy_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = XY_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = XY_MEM_DEPTH + 1,
    parameter int unsigned QUEUE_DEPTH = 4,
    localparam int unsigned IDX_WIDTH   = $clog2(QUEUE_DEPTH),
    localparam int unsigned COUNT_WIDTH = IDX_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   pop,
    input  logic                   kill,
    input  logic [ADDR_WIDTH-1:0]  kill_addr,
    output logic [ADDR_WIDTH-1:0]  head_addr,
    output logic [DATA_WIDTH-1:0]  head_data,
    output logic                   head_live,
    output logic                   empty,
    output logic                   full,
    output logic [COUNT_WIDTH-1:0] live_count
);

    logic [ADDR_WIDTH-1:0]  addr_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [COUNT_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [COUNT_WIDTH-1:0] live_count_q, live_count_d;
    logic [IDX_WIDTH-1:0]   wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[IDX_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[IDX_WIDTH-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_WIDTH] != rd_ptr_q[IDX_WIDTH]);

    assign head_addr  = addr_q[rd_idx];
    assign head_data  = data_q[rd_idx];
    // Slots are cleared on pop, so a set bit implies the slot is occupied.
    assign head_live  = valid_q[rd_idx];
    assign live_count = live_count_q;

    always_comb begin
        valid_d = valid_q;
        if (kill) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                if (addr_q[i] == kill_addr) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            valid_d[rd_idx] = 1'b0;
        end
        // Applied last: the arbiter never pushes an entry that matches a same-cycle kill.
        if (push) begin
            valid_d[wr_idx] = 1'b1;
        end
        live_count_d = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            live_count_d = live_count_d + COUNT_WIDTH'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            live_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            live_count_q <= live_count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + COUNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Payload storage needs no reset; liveness is tracked by valid_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_idx] <= push_addr;
            data_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/xy_write_arbiter.sv
// xy_write_arbiter: merges controller and host (buffer loader) writes onto the single XY memory
// write port. Controller writes are never stalled; host writes are queued behind them.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   host_valid/ready/addr/data  host write handshake
//   ctrl_write_enable/addr/data controller write, absolute priority
//   flush_request, flush_done   FLUSHBUFFER drain handshake
//   mem_write_enable/addr/data  registered XY memory write port
//   queue_count                 live queued host entries
module xy_write_arbiter
    import xy_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = XY_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = XY_MEM_DEPTH + 1,
    parameter int unsigned QUEUE_DEPTH = 4,
    localparam int unsigned COUNT_WIDTH = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0]  host_data,
    input  logic                   ctrl_write_enable,
    input  logic [ADDR_WIDTH-1:0]  ctrl_addr,
    input  logic [DATA_WIDTH-1:0]  ctrl_data,
    input  logic                   flush_request,
    output logic                   flush_done,
    output logic                   mem_write_enable,
    output logic [ADDR_WIDTH-1:0]  mem_write_addr,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    output logic [COUNT_WIDTH-1:0] queue_count
);

    logic                  queue_empty, queue_full, head_live;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  queue_push, queue_pop;
    logic                  host_accept, host_killed, bypass;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;

    logic                  mem_write_enable_q;
    logic [ADDR_WIDTH-1:0] mem_write_addr_q;
    logic [DATA_WIDTH-1:0] mem_write_data_q;

    // Readiness depends only on start-of-cycle occupancy; no pass-through when full.
    assign host_ready  = !queue_full;
    assign host_accept = host_valid && host_ready;
    // A same-cycle controller write to the same address supersedes the host write.
    assign host_killed = ctrl_write_enable && (host_addr == ctrl_addr);

    always_comb begin
        issue      = 1'b0;
        issue_addr = head_addr;
        issue_data = head_data;
        queue_pop  = 1'b0;
        bypass     = 1'b0;
        if (ctrl_write_enable) begin
            issue      = 1'b1;
            issue_addr = ctrl_addr;
            issue_data = ctrl_data;
        end else if (head_live) begin
            issue     = 1'b1;
            queue_pop = 1'b1;
        end else if (queue_empty && host_accept) begin
            issue      = 1'b1;
            bypass     = 1'b1;
            issue_addr = host_addr;
            issue_data = host_data;
        end
        // Killed heads never use the memory port, so drain them even under a controller write.
        if (!queue_empty && !head_live) begin
            queue_pop = 1'b1;
        end
        queue_push = host_accept && !bypass && !host_killed;
    end

    assign flush_done = flush_request && queue_empty && !bypass;

    xy_write_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (queue_push),
        .push_addr (host_addr),
        .push_data (host_data),
        .pop       (queue_pop),
        .kill      (ctrl_write_enable),
        .kill_addr (ctrl_addr),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_live (head_live),
        .empty     (queue_empty),
        .full      (queue_full),
        .live_count(queue_count)
    );

    // Address/data hold their last value when nothing issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write_enable_q <= 1'b0;
            mem_write_addr_q   <= '0;
            mem_write_data_q   <= '0;
        end else begin
            mem_write_enable_q <= issue;
            if (issue) begin
                mem_write_addr_q <= issue_addr;
                mem_write_data_q <= issue_data;
            end
        end
    end

    assign mem_write_enable = mem_write_enable_q;
    assign mem_write_addr   = mem_write_addr_q;
    assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_xy_write_arbiter.sv
module tb_xy_write_arbiter;
    import xy_write_arbiter_pkg::*;

    localparam int unsigned DW = XY_DATA_WIDTH;
    localparam int unsigned AW = XY_MEM_DEPTH + 1;
    localparam int unsigned QD = 4;
    localparam int unsigned CW = $clog2(QD) + 1;

    logic          clk;
    logic          reset;
    logic          host_valid;
    logic          host_ready;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          ctrl_write_enable;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_data;
    logic          flush_request;
    logic          flush_done;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic [CW-1:0] queue_count;

    XyWriteReq exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    xy_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .host_addr        (host_addr),
        .host_data        (host_data),
        .ctrl_write_enable(ctrl_write_enable),
        .ctrl_addr        (ctrl_addr),
        .ctrl_data        (ctrl_data),
        .flush_request    (flush_request),
        .flush_done       (flush_done),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .queue_count      (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic XyWriteReq req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        XyWriteReq r;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Advance one clock; any memory write now visible is popped from the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        if (!reset && mem_write_enable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_unexpected: write addr %0h data %0h, required no write",
                         mem_write_addr, mem_write_data);
            end else begin
                XyWriteReq e;
                e = exp_q.pop_front();
                if (mem_write_addr !== e.addr || mem_write_data !== e.data) begin
                    n_fails++;
                    $display("FAIL scoreboard_write: got addr %0h data %0h, required addr %0h data %0h",
                             mem_write_addr, mem_write_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        host_valid        = 1'b0;
        host_addr         = '0;
        host_data         = '0;
        ctrl_write_enable = 1'b0;
        ctrl_addr         = '0;
        ctrl_data         = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_request = 1'b0;
        idle_inputs();
        step();
        step();
        n_checks++;
        if (mem_write_enable !== 1'b0 || mem_write_addr !== '0 || mem_write_data !== '0) begin
            n_fails++;
            $display("FAIL reset_mem: got en %b addr %0h data %0h, required 0 0 0",
                     mem_write_enable, mem_write_addr, mem_write_data);
        end
        n_checks++;
        if (queue_count !== '0) begin
            n_fails++;
            $display("FAIL reset_count: got %0d, required 0", queue_count);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (host_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_host_ready: got %b, required 1", host_ready);
        end
        n_checks++;
        if (flush_done !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_flush_done_low: got %b, required 0", flush_done);
        end
        flush_request = 1'b1;
        #1;
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_flush_done_high: got %b, required 1", flush_done);
        end
        flush_request = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        host_valid = 1'b1;
        host_addr  = AW'(5);
        host_data  = 16'h1234;
        exp_q.push_back(req(AW'(5), 16'h1234));
        step();
        idle_inputs();
        n_checks++;
        if (mem_write_enable !== 1'b1 || mem_write_addr !== AW'(5) || mem_write_data !== 16'h1234) begin
            n_fails++;
            $display("FAIL bypass_latency: got en %b addr %0h data %0h, required 1 5 1234",
                     mem_write_enable, mem_write_addr, mem_write_data);
        end
        n_checks++;
        if (queue_count !== '0) begin
            n_fails++;
            $display("FAIL bypass_count: got %0d, required 0", queue_count);
        end
        step();
        n_checks++;
        if (mem_write_enable !== 1'b0 || mem_write_addr !== AW'(5) || mem_write_data !== 16'h1234) begin
            n_fails++;
            $display("FAIL bypass_hold: got en %b addr %0h data %0h, required 0 5 1234",
                     mem_write_enable, mem_write_addr, mem_write_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            ctrl_write_enable = 1'b1;
            ctrl_addr  = AW'(8'h40 + i);
            ctrl_data  = DW'(16'hC000 + i);
            host_valid = 1'b1;
            host_addr  = AW'(8'h10 + i);
            host_data  = DW'(16'hB000 + i);
            exp_q.push_back(req(AW'(8'h40 + i), DW'(16'hC000 + i)));
            #1;
            n_checks++;
            if (host_ready !== (i < 4)) begin
                n_fails++;
                $display("FAIL b2b_host_ready[%0d]: got %b, required %b", i, host_ready, (i < 4));
            end
            step();
        end
        idle_inputs();
        n_checks++;
        if (queue_count !== CW'(4)) begin
            n_fails++;
            $display("FAIL b2b_count_full: got %0d, required 4", queue_count);
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(req(AW'(8'h10 + k), DW'(16'hB000 + k)));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (mem_write_enable !== 1'b1 || mem_write_addr !== AW'(8'h10 + k)) begin
                n_fails++;
                $display("FAIL b2b_drain[%0d]: got en %b addr %0h, required 1 %0h",
                         k, mem_write_enable, mem_write_addr, 8'h10 + k);
            end
        end
        step();
        n_checks++;
        if (mem_write_enable !== 1'b0 || queue_count !== '0) begin
            n_fails++;
            $display("FAIL b2b_empty: got en %b count %0d, required 0 0",
                     mem_write_enable, queue_count);
        end
    endtask

    task automatic test_hazard_kill();
        ctrl_write_enable = 1'b1;
        ctrl_addr  = AW'(8'h20);
        ctrl_data  = 16'h1111;
        host_valid = 1'b1;
        host_addr  = AW'(7);
        host_data  = 16'hAAAA;
        exp_q.push_back(req(AW'(8'h20), 16'h1111));
        step();
        ctrl_addr = AW'(7);
        ctrl_data = 16'h5555;
        host_addr = AW'(8);
        host_data = 16'hBBBB;
        exp_q.push_back(req(AW'(7), 16'h5555));
        step();
        idle_inputs();
        n_checks++;
        if (queue_count !== CW'(1)) begin
            n_fails++;
            $display("FAIL kill_count: got %0d, required 1", queue_count);
        end
        exp_q.push_back(req(AW'(8), 16'hBBBB));
        step();
        n_checks++;
        if (mem_write_enable !== 1'b0 || mem_write_data !== 16'h5555) begin
            n_fails++;
            $display("FAIL kill_silent_pop: got en %b data %0h, required 0 5555",
                     mem_write_enable, mem_write_data);
        end
        step();
        n_checks++;
        if (mem_write_enable !== 1'b1 || mem_write_addr !== AW'(8)) begin
            n_fails++;
            $display("FAIL kill_next_entry: got en %b addr %0h, required 1 8",
                     mem_write_enable, mem_write_addr);
        end
        step();
        n_checks++;
        if (queue_count !== '0) begin
            n_fails++;
            $display("FAIL kill_drained: got %0d, required 0", queue_count);
        end
    endtask

    task automatic test_same_cycle_hazard();
        ctrl_write_enable = 1'b1;
        ctrl_addr  = AW'(9);
        ctrl_data  = 16'h7777;
        host_valid = 1'b1;
        host_addr  = AW'(9);
        host_data  = 16'h9999;
        exp_q.push_back(req(AW'(9), 16'h7777));
        #1;
        n_checks++;
        if (host_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL same_cycle_ready: got %b, required 1", host_ready);
        end
        step();
        idle_inputs();
        n_checks++;
        if (queue_count !== '0) begin
            n_fails++;
            $display("FAIL same_cycle_dropped: got count %0d, required 0", queue_count);
        end
        step();
        n_checks++;
        if (mem_write_enable !== 1'b0 || host_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL same_cycle_no_host: got en %b ready %b, required 0 1",
                     mem_write_enable, host_ready);
        end
    endtask

    task automatic test_flush();
        flush_request = 1'b1;
        #1;
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_idle: got %b, required 1", flush_done);
        end
        host_valid = 1'b1;
        host_addr  = AW'(8'h50);
        host_data  = 16'h5050;
        exp_q.push_back(req(AW'(8'h50), 16'h5050));
        #1;
        n_checks++;
        if (flush_done !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_bypass: got %b, required 0", flush_done);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            ctrl_write_enable = 1'b1;
            ctrl_addr  = AW'(8'h60 + i);
            ctrl_data  = DW'(16'h6000 + i);
            host_valid = 1'b1;
            host_addr  = AW'(8'h30 + i);
            host_data  = DW'(16'h3000 + i);
            exp_q.push_back(req(AW'(8'h60 + i), DW'(16'h6000 + i)));
            step();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(req(AW'(8'h30 + k), DW'(16'h3000 + k)));
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (flush_done !== 1'b0) begin
                n_fails++;
                $display("FAIL flush_pending[%0d]: got %b, required 0", k, flush_done);
            end
            step();
        end
        #1;
        n_checks++;
        if (flush_done !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_done_after_drain: got %b, required 1", flush_done);
        end
        flush_request = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            ctrl_write_enable = 1'b1;
            ctrl_addr  = AW'(8'h70 + i);
            ctrl_data  = DW'(16'h7000 + i);
            host_valid = 1'b1;
            host_addr  = AW'(8'h38 + i);
            host_data  = DW'(16'h3800 + i);
            exp_q.push_back(req(AW'(8'h70 + i), DW'(16'h7000 + i)));
            step();
        end
        idle_inputs();
        n_checks++;
        if (queue_count !== CW'(3)) begin
            n_fails++;
            $display("FAIL reset_mid_loaded: got %0d, required 3", queue_count);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_write_enable !== 1'b0 || mem_write_addr !== '0 || mem_write_data !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_mem: got en %b addr %0h data %0h, required 0 0 0",
                     mem_write_enable, mem_write_addr, mem_write_data);
        end
        n_checks++;
        if (queue_count !== '0 || host_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_mid_queue: got count %0d ready %b, required 0 1",
                     queue_count, host_ready);
        end
        step();
        #2 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (mem_write_enable !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_mid_no_write[%0d]: got en %b addr %0h, required 0",
                         k, mem_write_enable, mem_write_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_back_to_back();
        test_hazard_kill();
        test_same_cycle_hazard();
        test_flush();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_leftover: got %0d pending writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
